// File: rtl/slink_pkg.sv
// Shared definitions for the slink receive frame checker.
package slink_pkg;

  localparam int unsigned SLK_W   = 18;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned ID_W    = 8;
  localparam int unsigned STA_W   = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SLK_SOP = 17;
  localparam int unsigned SLK_EOP = 16;

  // FIFO read word: sop/eop flags above a 16-bit word (first byte in 15:8).
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [WORD_W-1:0] word;
  } slk_word_t;

  // Per-frame termination status.
  typedef enum logic [STA_W-1:0] {
    STA_OK     = 3'd0,
    STA_NOSOP  = 3'd1,
    STA_EOP    = 3'd2,
    STA_LEN    = 3'd3,
    STA_CSUM   = 3'd4,
    STA_ID     = 3'd5,
    STA_SOPMID = 3'd6
  } sta_e;

  // Frame parser states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_PLD  = 3'd2,
    ST_CHK  = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  // Payload words needed to carry len bytes.
  function automatic logic [WORD_W-1:0] nwords(input logic [WORD_W-1:0] len);
    nwords = WORD_W'((17'(len) + 17'd1) >> 1);
  endfunction

endpackage

// File: rtl/slink_sat_cnt16.sv
// 16-bit counter that sticks at all-ones.
module slink_sat_cnt16
  import slink_pkg::*;
(
  input  logic             clk_125m,
  input  logic             rst_125m,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Increment on request unless already saturated.
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slink_rx_frmchk.sv
// Parses slink frames from the packet FIFO, checks them and streams payload.
module slink_rx_frmchk
  import slink_pkg::*;
#(
  parameter int unsigned    MAX_LEN  = 1024,
  parameter logic [ID_W-1:0] BCAST_ID = 8'hFF
) (
  input  logic              clk_125m,
  input  logic              rst_125m,
  input  logic              slink_mm_empty,
  input  logic              slink_mm_dval,
  input  logic [SLK_W-1:0]  slink_mm_data,
  output logic              mm_slink_rdreq,
  input  logic [ID_W-1:0]   local_id,
  input  logic              frm_afull,
  output logic              frm_dval,
  output logic              frm_sop,
  output logic              frm_eop,
  output logic [1:0]        frm_be,
  output logic [WORD_W-1:0] frm_data,
  output logic              frm_err,
  output logic              frm_sta_vld,
  output logic [STA_W-1:0]  frm_sta,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     hdr_id_q, hdr_id_d;
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic [WORD_W-1:0]   rem_q, rem_d;
  logic                len_odd_q, len_odd_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                hold_first_q, hold_first_d;

  logic                dval_d, sop_d, eop_d, err_d, sta_vld_d;
  logic [1:0]          be_d;
  logic [WORD_W-1:0]   data_d;
  sta_e                sta_d;

  logic                start_hdr_c;
  logic                abort_c;
  logic                id_ok_c;
  logic                good_inc_c;
  logic                err_inc_c;
  slk_word_t           w_c;

  assign w_c            = slk_word_t'(slink_mm_data);
  assign mm_slink_rdreq = !slink_mm_empty && !frm_afull;
  assign id_ok_c        = (hdr_id_q == local_id) || (hdr_id_q == BCAST_ID);

  // FSM state register.
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath updates and next output values; advances only on dval.
  always_comb begin
    state_d      = state_q;
    hdr_id_d     = hdr_id_q;
    sum_d        = sum_q;
    rem_d        = rem_q;
    len_odd_d    = len_odd_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    hold_first_d = hold_first_q;
    dval_d       = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    err_d        = 1'b0;
    be_d         = 2'b00;
    data_d       = '0;
    sta_vld_d    = 1'b0;
    sta_d        = STA_OK;
    start_hdr_c  = 1'b0;
    abort_c      = 1'b0;

    if (slink_mm_dval) begin
      unique case (state_q)
        ST_IDLE, ST_DROP: begin
          if (w_c.sop) begin
            start_hdr_c = 1'b1;
          end else if (state_q == ST_IDLE) begin
            sta_vld_d = 1'b1;
            sta_d     = STA_NOSOP;
            state_d   = w_c.eop ? ST_IDLE : ST_DROP;
          end else if (w_c.eop) begin
            state_d = ST_IDLE;
          end
        end

        ST_LEN: begin
          if (w_c.sop) begin
            sta_vld_d   = 1'b1;
            sta_d       = STA_SOPMID;
            start_hdr_c = 1'b1;
          end else if (w_c.eop) begin
            sta_vld_d = 1'b1;
            sta_d     = STA_EOP;
            state_d   = ST_IDLE;
          end else if (w_c.word > WORD_W'(MAX_LEN)) begin
            sta_vld_d = 1'b1;
            sta_d     = STA_LEN;
            state_d   = ST_DROP;
          end else if (!id_ok_c) begin
            sta_vld_d = 1'b1;
            sta_d     = STA_ID;
            state_d   = ST_DROP;
          end else begin
            sum_d     = sum_q + w_c.word;
            len_odd_d = w_c.word[0];
            rem_d     = nwords(w_c.word);
            state_d   = (w_c.word == '0) ? ST_CHK : ST_PLD;
          end
        end

        ST_PLD: begin
          if (w_c.sop) begin
            sta_vld_d   = 1'b1;
            sta_d       = STA_SOPMID;
            abort_c     = 1'b1;
            start_hdr_c = 1'b1;
          end else if (w_c.eop) begin
            sta_vld_d = 1'b1;
            sta_d     = STA_EOP;
            abort_c   = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            // Previous word goes out now that a successor exists.
            if (hold_vld_q) begin
              dval_d = 1'b1;
              sop_d  = hold_first_q;
              be_d   = 2'b11;
              data_d = hold_q;
            end
            sum_d        = sum_q + w_c.word;
            hold_d       = w_c.word;
            hold_vld_d   = 1'b1;
            hold_first_d = !hold_vld_q;
            rem_d        = rem_q - WORD_W'(1);
            if (rem_q == WORD_W'(1)) begin
              state_d = ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (w_c.sop) begin
            sta_vld_d   = 1'b1;
            sta_d       = STA_SOPMID;
            abort_c     = 1'b1;
            start_hdr_c = 1'b1;
          end else if (!w_c.eop) begin
            sta_vld_d = 1'b1;
            sta_d     = STA_EOP;
            abort_c   = 1'b1;
            state_d   = ST_DROP;
          end else begin
            sta_vld_d = 1'b1;
            sta_d     = (w_c.word == sum_q) ? STA_OK : STA_CSUM;
            state_d   = ST_IDLE;
            if (hold_vld_q) begin
              dval_d     = 1'b1;
              sop_d      = hold_first_q;
              eop_d      = 1'b1;
              err_d      = (w_c.word != sum_q);
              be_d       = len_odd_q ? 2'b10 : 2'b11;
              data_d     = hold_q;
              hold_vld_d = 1'b0;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // A sop word opens a new frame; eop on the header itself ends it at once.
    if (start_hdr_c) begin
      hdr_id_d     = w_c.word[WORD_W-1 -: ID_W];
      sum_d        = w_c.word;
      hold_vld_d   = 1'b0;
      hold_first_d = 1'b0;
      if (w_c.eop) begin
        state_d = ST_IDLE;
        if (!sta_vld_d) begin
          sta_vld_d = 1'b1;
          sta_d     = STA_EOP;
        end
      end else begin
        state_d = ST_LEN;
      end
    end

    // Aborted frame with payload in flight: flush the held word as a bad eop.
    if (abort_c && hold_vld_q) begin
      dval_d     = 1'b1;
      sop_d      = hold_first_q;
      eop_d      = 1'b1;
      err_d      = 1'b1;
      be_d       = 2'b11;
      data_d     = hold_q;
      hold_vld_d = 1'b0;
    end
  end

  // Frame context and one-word payload hold register.
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      hdr_id_q     <= '0;
      sum_q        <= '0;
      rem_q        <= '0;
      len_odd_q    <= 1'b0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      hold_first_q <= 1'b0;
    end else begin
      hdr_id_q     <= hdr_id_d;
      sum_q        <= sum_d;
      rem_q        <= rem_d;
      len_odd_q    <= len_odd_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      hold_first_q <= hold_first_d;
    end
  end

  // Registered downstream stream and status outputs.
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      frm_dval    <= 1'b0;
      frm_sop     <= 1'b0;
      frm_eop     <= 1'b0;
      frm_be      <= 2'b00;
      frm_data    <= '0;
      frm_err     <= 1'b0;
      frm_sta_vld <= 1'b0;
      frm_sta     <= '0;
    end else begin
      frm_dval    <= dval_d;
      frm_sop     <= sop_d;
      frm_eop     <= eop_d;
      frm_be      <= be_d;
      frm_data    <= data_d;
      frm_err     <= err_d;
      frm_sta_vld <= sta_vld_d;
      frm_sta     <= sta_d;
    end
  end

  // ID mismatch is a filter, not an error, so it bumps neither counter.
  assign good_inc_c = sta_vld_d && (sta_d == STA_OK);
  assign err_inc_c  = sta_vld_d && (sta_d != STA_OK) && (sta_d != STA_ID);

  slink_sat_cnt16 u_good_cnt (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .inc      (good_inc_c),
    .cnt      (good_cnt)
  );

  slink_sat_cnt16 u_err_cnt (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .inc      (err_inc_c),
    .cnt      (err_cnt)
  );

endmodule

// File: tb/tb_slink_rx_frmchk.sv
// Directed bench for slink_rx_frmchk with a one-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_slink_rx_frmchk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  be;
    logic        err;
    logic        sv;
    logic [15:0] data;
  } beat_t;

  logic        clk_125m = 1'b0;
  logic        rst_125m = 1'b0;
  logic        slink_mm_empty = 1'b1;
  logic        slink_mm_dval = 1'b0;
  logic [17:0] slink_mm_data = '0;
  logic        mm_slink_rdreq;
  logic [7:0]  local_id = 8'h05;
  logic        frm_afull = 1'b0;
  logic        frm_dval, frm_sop, frm_eop, frm_err, frm_sta_vld;
  logic [1:0]  frm_be;
  logic [15:0] frm_data;
  logic [2:0]  frm_sta;
  logic [15:0] good_cnt, err_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [17:0] fifo_q[$];
  bit          pend_s = 1'b0;
  beat_t       out_q[$];
  logic [2:0]  sta_q[$];
  beat_t       good_exp[3];

  slink_rx_frmchk dut (
    .clk_125m       (clk_125m),
    .rst_125m       (rst_125m),
    .slink_mm_empty (slink_mm_empty),
    .slink_mm_dval  (slink_mm_dval),
    .slink_mm_data  (slink_mm_data),
    .mm_slink_rdreq (mm_slink_rdreq),
    .local_id       (local_id),
    .frm_afull      (frm_afull),
    .frm_dval       (frm_dval),
    .frm_sop        (frm_sop),
    .frm_eop        (frm_eop),
    .frm_be         (frm_be),
    .frm_data       (frm_data),
    .frm_err        (frm_err),
    .frm_sta_vld    (frm_sta_vld),
    .frm_sta        (frm_sta),
    .good_cnt       (good_cnt),
    .err_cnt        (err_cnt)
  );

  always #4 clk_125m = ~clk_125m;

  // FIFO model: a request seen at a rising edge returns data one cycle later.
  always @(posedge clk_125m) pend_s = mm_slink_rdreq;

  always @(negedge clk_125m) begin
    if (pend_s && fifo_q.size() > 0) begin
      slink_mm_dval = 1'b1;
      slink_mm_data = fifo_q.pop_front();
    end else begin
      slink_mm_dval = 1'b0;
      slink_mm_data = '0;
    end
    slink_mm_empty = (fifo_q.size() == 0);
  end

  // Output monitor.
  always @(negedge clk_125m) begin
    if (frm_dval) out_q.push_back({frm_sop, frm_eop, frm_be, frm_err, frm_sta_vld, frm_data});
    if (frm_sta_vld) sta_q.push_back(frm_sta);
  end

  function automatic beat_t mk(input logic sop, input logic eop, input logic [1:0] be,
                               input logic err, input logic sv, input logic [15:0] d);
    mk = {sop, eop, be, err, sv, d};
  endfunction

  function automatic beat_t get_beat(input int idx);
    get_beat = (idx < out_q.size()) ? out_q[idx] : 'x;
  endfunction

  function automatic logic [2:0] get_sta(input int idx);
    get_sta = (idx < sta_q.size()) ? sta_q[idx] : 3'bxxx;
  endfunction

  task automatic push(input logic sop, input logic eop, input logic [15:0] w);
    fifo_q.push_back({sop, eop, w});
  endtask

  task automatic push_frame(input logic [15:0] hdr, input logic [15:0] len, input int n,
                            input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input logic [15:0] chk);
    push(1'b1, 1'b0, hdr);
    push(1'b0, 1'b0, len);
    if (n > 0) push(1'b0, 1'b0, p0);
    if (n > 1) push(1'b0, 1'b0, p1);
    if (n > 2) push(1'b0, 1'b0, p2);
    push(1'b0, 1'b1, chk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || pend_s) && n < 500) begin
      @(negedge clk_125m);
      n++;
    end
    repeat (4) @(negedge clk_125m);
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL %s_drain timeout left=%0d required=0", name, fifo_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_125m);
    checks++;
    if ({frm_dval, frm_sop, frm_eop, frm_be, frm_data, frm_err, frm_sta_vld, frm_sta} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0",
               {frm_dval, frm_sop, frm_eop, frm_be, frm_data, frm_err, frm_sta_vld, frm_sta});
    end
    checks++;
    if ({good_cnt, err_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL reset_counters got=%h required=0", {good_cnt, err_cnt});
    end
    checks++;
    if (mm_slink_rdreq !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdreq got=%b required=0", mm_slink_rdreq);
    end
    rst_125m = 1'b1;
    repeat (2) @(negedge clk_125m);
  endtask

  task automatic test_good_frame;
    int ob = out_q.size();
    int sb = sta_q.size();
    push_frame(16'h0512, 16'h0005, 3, 16'h1122, 16'h3344, 16'h5500, 16'h9E7D);
    wait_drain("good");
    checks++;
    if (out_q.size() - ob !== 3) begin
      failures++;
      $display("FAIL good_nbeats got=%0d required=3", out_q.size() - ob);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_beat(ob + i) !== good_exp[i]) begin
        failures++;
        $display("FAIL good_beat%0d got=%h required=%h", i, get_beat(ob + i), good_exp[i]);
      end
    end
    checks++;
    if (sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd0) begin
      failures++;
      $display("FAIL good_sta got=%0d (n=%0d) required=0 (n=1)", get_sta(sb), sta_q.size() - sb);
    end
    checks++;
    if (good_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL good_cnts got=%0d/%0d required=1/0", good_cnt, err_cnt);
    end
  endtask

  task automatic test_bad_checksum;
    int ob = out_q.size();
    int sb = sta_q.size();
    beat_t exp_last = mk(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 16'h5500);
    push_frame(16'h0512, 16'h0005, 3, 16'h1122, 16'h3344, 16'h5500, 16'h0000);
    wait_drain("csum");
    checks++;
    if (out_q.size() - ob !== 3) begin
      failures++;
      $display("FAIL csum_nbeats got=%0d required=3", out_q.size() - ob);
    end
    checks++;
    if (get_beat(ob + 2) !== exp_last) begin
      failures++;
      $display("FAIL csum_last got=%h required=%h", get_beat(ob + 2), exp_last);
    end
    checks++;
    if (sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd4) begin
      failures++;
      $display("FAIL csum_sta got=%0d required=4", get_sta(sb));
    end
    checks++;
    if (good_cnt !== 16'd1 || err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL csum_cnts got=%0d/%0d required=1/1", good_cnt, err_cnt);
    end
  endtask

  task automatic test_bcast_and_id;
    int ob = out_q.size();
    int sb = sta_q.size();
    push_frame(16'hFF00, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 16'hFF00);
    wait_drain("bcast");
    checks++;
    if (out_q.size() !== ob || sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd0) begin
      failures++;
      $display("FAIL bcast_zero got beats=%0d sta=%0d required beats=0 sta=0",
               out_q.size() - ob, get_sta(sb));
    end
    checks++;
    if (good_cnt !== 16'd2) begin
      failures++;
      $display("FAIL bcast_good_cnt got=%0d required=2", good_cnt);
    end
    sb = sta_q.size();
    push_frame(16'h0700, 16'h0002, 1, 16'h0102, 16'h0, 16'h0, 16'h0804);
    wait_drain("id");
    checks++;
    if (out_q.size() !== ob || sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd5) begin
      failures++;
      $display("FAIL id_sta got beats=%0d sta=%0d required beats=0 sta=5",
               out_q.size() - ob, get_sta(sb));
    end
    checks++;
    if (good_cnt !== 16'd2 || err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL id_cnts got=%0d/%0d required=2/1", good_cnt, err_cnt);
    end
  endtask

  task automatic test_early_eop;
    int ob = out_q.size();
    int sb = sta_q.size();
    beat_t e0 = mk(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 16'hAAAA);
    beat_t e1 = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 16'h1234);
    push(1'b1, 1'b0, 16'h0500);
    push(1'b0, 1'b0, 16'h0006);
    push(1'b0, 1'b0, 16'hAAAA);
    push(1'b0, 1'b1, 16'hBBBB);
    wait_drain("early");
    checks++;
    if (out_q.size() - ob !== 1 || get_beat(ob) !== e0) begin
      failures++;
      $display("FAIL early_beat got=%h n=%0d required=%h n=1", get_beat(ob), out_q.size() - ob, e0);
    end
    checks++;
    if (get_sta(sb) !== 3'd2 || err_cnt !== 16'd2) begin
      failures++;
      $display("FAIL early_sta got sta=%0d err=%0d required sta=2 err=2", get_sta(sb), err_cnt);
    end
    ob = out_q.size();
    sb = sta_q.size();
    push_frame(16'h0501, 16'h0002, 1, 16'h1234, 16'h0, 16'h0, 16'h1737);
    wait_drain("after_early");
    checks++;
    if (out_q.size() - ob !== 1 || get_beat(ob) !== e1) begin
      failures++;
      $display("FAIL after_early_beat got=%h required=%h", get_beat(ob), e1);
    end
    checks++;
    if (get_sta(sb) !== 3'd0 || good_cnt !== 16'd3) begin
      failures++;
      $display("FAIL after_early_sta got sta=%0d good=%0d required sta=0 good=3", get_sta(sb), good_cnt);
    end
  endtask

  task automatic test_len_and_nosop;
    int ob = out_q.size();
    int sb = sta_q.size();
    push_frame(16'h0500, 16'h0401, 2, 16'h0001, 16'h0002, 16'h0, 16'h0003);
    wait_drain("len");
    checks++;
    if (out_q.size() !== ob || sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd3) begin
      failures++;
      $display("FAIL len_sta got beats=%0d sta=%0d required beats=0 sta=3",
               out_q.size() - ob, get_sta(sb));
    end
    sb = sta_q.size();
    push(1'b0, 1'b0, 16'h1111);
    push(1'b0, 1'b0, 16'h2222);
    push(1'b0, 1'b1, 16'h3333);
    wait_drain("nosop");
    checks++;
    if (out_q.size() !== ob || sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd1) begin
      failures++;
      $display("FAIL nosop_sta got beats=%0d n=%0d sta=%0d required beats=0 n=1 sta=1",
               out_q.size() - ob, sta_q.size() - sb, get_sta(sb));
    end
    checks++;
    if (err_cnt !== 16'd4) begin
      failures++;
      $display("FAIL nosop_err_cnt got=%0d required=4", err_cnt);
    end
  endtask

  task automatic test_afull_hold;
    int ob, sb;
    frm_afull = 1'b1;
    repeat (3) @(negedge clk_125m);
    ob = out_q.size();
    sb = sta_q.size();
    push_frame(16'h0512, 16'h0005, 3, 16'h1122, 16'h3344, 16'h5500, 16'h9E7D);
    repeat (10) @(negedge clk_125m);
    checks++;
    if (mm_slink_rdreq !== 1'b0 || fifo_q.size() !== 6) begin
      failures++;
      $display("FAIL afull_hold got rdreq=%b left=%0d required rdreq=0 left=6",
               mm_slink_rdreq, fifo_q.size());
    end
    checks++;
    if (out_q.size() !== ob || sta_q.size() !== sb) begin
      failures++;
      $display("FAIL afull_hold_out got beats=%0d sta=%0d required 0/0",
               out_q.size() - ob, sta_q.size() - sb);
    end
    frm_afull = 1'b0;
    wait_drain("afull_hold");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_beat(ob + i) !== good_exp[i]) begin
        failures++;
        $display("FAIL afull_hold_beat%0d got=%h required=%h", i, get_beat(ob + i), good_exp[i]);
      end
    end
    checks++;
    if (get_sta(sb) !== 3'd0 || good_cnt !== 16'd4) begin
      failures++;
      $display("FAIL afull_hold_sta got sta=%0d good=%0d required 0/4", get_sta(sb), good_cnt);
    end
  endtask

  task automatic test_afull_toggle;
    int ob = out_q.size();
    int sb = sta_q.size();
    int n = 0;
    push_frame(16'h0512, 16'h0005, 3, 16'h1122, 16'h3344, 16'h5500, 16'h9E7D);
    while ((fifo_q.size() != 0 || pend_s) && n < 500) begin
      @(negedge clk_125m);
      frm_afull = ~frm_afull;
      n++;
    end
    frm_afull = 1'b0;
    wait_drain("toggle");
    checks++;
    if (n >= 500 || out_q.size() - ob !== 3) begin
      failures++;
      $display("FAIL toggle_nbeats got=%0d cycles=%0d required=3", out_q.size() - ob, n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_beat(ob + i) !== good_exp[i]) begin
        failures++;
        $display("FAIL toggle_beat%0d got=%h required=%h", i, get_beat(ob + i), good_exp[i]);
      end
    end
    checks++;
    if (get_sta(sb) !== 3'd0 || good_cnt !== 16'd5) begin
      failures++;
      $display("FAIL toggle_sta got sta=%0d good=%0d required 0/5", get_sta(sb), good_cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    int ob = out_q.size();
    int sb;
    push(1'b1, 1'b0, 16'h0512);
    push(1'b0, 1'b0, 16'h0005);
    push(1'b0, 1'b0, 16'h1122);
    push(1'b0, 1'b0, 16'h3344);
    wait_drain("midrst_pre");
    checks++;
    if (out_q.size() - ob !== 1) begin
      failures++;
      $display("FAIL midrst_pre_beats got=%0d required=1", out_q.size() - ob);
    end
    #2;
    rst_125m = 1'b0;
    #1;
    checks++;
    if ({good_cnt, err_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL midrst_counters got=%h required=0", {good_cnt, err_cnt});
    end
    checks++;
    if ({frm_dval, frm_sop, frm_eop, frm_be, frm_data, frm_err, frm_sta_vld, frm_sta} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b required=0",
               {frm_dval, frm_sop, frm_eop, frm_be, frm_data, frm_err, frm_sta_vld, frm_sta});
    end
    @(negedge clk_125m);
    rst_125m = 1'b1;
    @(negedge clk_125m);
    ob = out_q.size();
    sb = sta_q.size();
    push(1'b0, 1'b0, 16'h5500);
    push(1'b0, 1'b1, 16'h9E7D);
    wait_drain("midrst_post");
    checks++;
    if (out_q.size() !== ob || sta_q.size() - sb !== 1 || get_sta(sb) !== 3'd1) begin
      failures++;
      $display("FAIL midrst_sta got beats=%0d n=%0d sta=%0d required beats=0 n=1 sta=1",
               out_q.size() - ob, sta_q.size() - sb, get_sta(sb));
    end
    checks++;
    if (good_cnt !== 16'd0 || err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL midrst_cnts got=%0d/%0d required=0/1", good_cnt, err_cnt);
    end
  endtask

  initial begin
    good_exp[0] = mk(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 16'h1122);
    good_exp[1] = mk(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 16'h3344);
    good_exp[2] = mk(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 16'h5500);
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_bcast_and_id;
    test_early_eop;
    test_len_and_nosop;
    test_afull_hold;
    test_afull_toggle;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
